fetch_stage: RTL and testbench

Instruction-fetch stage of the MIPS soft core. Owns the program counter and drives it to the PC adder. Consumes the adder's PC+4 result. Issues requests to instruction memory over a req/ack handshake and loads the IF/ID pipeline register. Supports hazard stall, a one-entry skid buffer, and branch/jump redirect with discard of in-flight fetches.

---
 rtl/mips_pkg.sv | 19 +
 rtl/if_id_reg.sv | 38 +++
 rtl/fetch_stage.sv | 150 +++++++++++++++
 tb/tb_fetch_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS soft core front end: reset defaults,
// the canonical NOP, fetch FSM encoding and word alignment.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] WORD_ALIGN_MASK   = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with flush > load > bubble > hold priority.
// A bubble only drops valid; a flush also replaces the word with a NOP.
module if_id_reg import mips_pkg::*; #(
  parameter logic [31:0] NOP = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic        bubble,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc4_in,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc4
);

  // pipeline register update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= NOP;
      pc4   <= 32'h0000_0000;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= NOP;
    end else if (load) begin
      valid <= 1'b1;
      instr <= instr_in;
      pc4   <= pc4_in;
    end else if (bubble) begin
      valid <= 1'b0;
    end else begin
      valid <= valid;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake,
// buffers one fetched word while stalled and discards fetches made stale by a redirect.
module fetch_stage import mips_pkg::*; #(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_out,
  input  logic [31:0] pc_plus4_in,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4
);

  fetch_state_t state, state_nx;
  logic [31:0]  pc, pc_nx;
  logic         req, req_nx;
  logic [31:0]  addr, addr_nx;
  logic [31:0]  skid_instr, skid_instr_nx;
  logic [31:0]  skid_pc4, skid_pc4_nx;
  logic         ack;
  logic         ifid_load, ifid_flush, ifid_bubble;
  logic [31:0]  ifid_instr_in, ifid_pc4_in;

  // state, PC, request and skid registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      req        <= 1'b0;
      addr       <= RESET_PC;
      skid_instr <= NOP_INSTR;
      skid_pc4   <= 32'h0000_0000;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      req        <= req_nx;
      addr       <= addr_nx;
      skid_instr <= skid_instr_nx;
      skid_pc4   <= skid_pc4_nx;
    end
  end

  // next-state and IF/ID control; redirect outranks stall and ack
  always_comb begin
    state_nx      = state;
    pc_nx         = pc;
    req_nx        = req;
    addr_nx       = addr;
    skid_instr_nx = skid_instr;
    skid_pc4_nx   = skid_pc4;
    ifid_load     = 1'b0;
    ifid_flush    = 1'b0;
    ifid_bubble   = 1'b0;
    ifid_instr_in = imem_rdata;
    ifid_pc4_in   = pc_plus4_in;
    ack           = imem_ack & req;

    if (redirect) begin
      pc_nx         = word_align(redirect_pc);
      ifid_flush    = 1'b1;
      skid_instr_nx = NOP_INSTR;
      skid_pc4_nx   = 32'h0000_0000;
      if (req && !ack) begin
        // memory still owes us a word at the old address: swallow it first
        state_nx = S_DRAIN;
      end else begin
        req_nx   = 1'b1;
        addr_nx  = word_align(redirect_pc);
        state_nx = S_REQ;
      end
    end else begin
      case (state)
        S_REQ: begin
          if (!req) begin
            req_nx      = 1'b1;
            addr_nx     = pc;
            ifid_bubble = !stall;
          end else if (ack) begin
            pc_nx = pc_plus4_in;
            if (!stall) begin
              ifid_load = 1'b1;
              addr_nx   = pc_plus4_in;
            end else begin
              skid_instr_nx = imem_rdata;
              skid_pc4_nx   = pc_plus4_in;
              req_nx        = 1'b0;
              state_nx      = S_HOLD;
            end
          end else begin
            ifid_bubble = !stall;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            ifid_load     = 1'b1;
            ifid_instr_in = skid_instr;
            ifid_pc4_in   = skid_pc4;
            req_nx        = 1'b1;
            addr_nx       = pc;
            state_nx      = S_REQ;
          end else begin
            state_nx = S_HOLD;
          end
        end
        S_DRAIN: begin
          if (ack) begin
            addr_nx  = pc;
            state_nx = S_REQ;
          end else begin
            state_nx = S_DRAIN;
          end
        end
        default: begin
          req_nx   = 1'b0;
          addr_nx  = pc;
          state_nx = S_REQ;
        end
      endcase
    end
  end

  if_id_reg #(
    .NOP (NOP_INSTR)
  ) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .load     (ifid_load),
    .flush    (ifid_flush),
    .bubble   (ifid_bubble),
    .instr_in (ifid_instr_in),
    .pc4_in   (ifid_pc4_in),
    .valid    (if_id_valid),
    .instr    (if_id_instr),
    .pc4      (if_id_pc4)
  );

  assign pc_out    = pc;
  assign imem_req  = req;
  assign imem_addr = addr;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised bench for fetch_stage: the reference is the program-order word
// stream (pc, pc+4, ... restarted at each redirect target), checked by a scoreboard.
module tb_fetch_stage;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  localparam logic [31:0] DATA_KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic        clk, rst, stall, redirect;
  logic [31:0] redirect_pc, pc_out, pc_plus4_in, imem_addr, imem_rdata;
  logic        imem_req, imem_ack, if_id_valid;
  logic [31:0] if_id_instr, if_id_pc4;

  int          checks = 0;
  int          errors = 0;
  int          pops = 0;
  int          max_lat = 0;
  exp_t        exp_q[$];
  logic [31:0] model_pc;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc_out      (pc_out),
    .pc_plus4_in (pc_plus4_in),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_id_valid (if_id_valid),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4)
  );

  // external PC adder
  assign pc_plus4_in = pc_out + 32'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic topup();
    while (exp_q.size() < 8) begin
      exp_q.push_back('{instr: model_pc ^ DATA_KEY, pc4: model_pc + 32'd4});
      model_pc = model_pc + 32'd4;
    end
  endtask

  task automatic check_reset_values();
    chk("rst_pc_out", pc_out, 32'h0000_0000);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0000_0000);
    chk("rst_valid", 32'(if_id_valid), 32'd0);
    chk("rst_instr", if_id_instr, NOP);
    chk("rst_pc4", if_id_pc4, 32'h0000_0000);
  endtask

  // instruction memory: random latency, junk acks whenever no request is up
  initial begin
    logic pending;
    int   wait_left;
    pending    = 1'b0;
    wait_left  = 0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0000_0000;
    forever begin
      @(negedge clk);
      if (rst || !imem_req) begin
        pending    = 1'b0;
        imem_ack   = ($urandom_range(0, 3) == 0);
        imem_rdata = 32'hDEAD_BEEF;
      end else begin
        if (!pending) begin
          pending = 1'b1;
          if (max_lat == 0 || $urandom_range(0, 1) == 0) wait_left = 0;
          else wait_left = $urandom_range(1, max_lat);
        end
        if (wait_left == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = imem_addr ^ DATA_KEY;
          pending    = 1'b0;
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = 32'hDEAD_BEEF;
          wait_left--;
        end
      end
    end
  end

  // monitor: snapshot just before each edge, check just after it
  initial begin
    logic p_rst, p_stall, p_redirect, p_req, p_ack, have_last;
    logic [31:0] p_addr;
    exp_t last, got;
    have_last = 1'b0;
    last = '0;
    forever begin
      @(negedge clk); #4;
      p_rst = rst; p_stall = stall; p_redirect = redirect;
      p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
      @(posedge clk); #1;
      if (p_rst || rst) begin
        have_last = 1'b0;
      end else begin
        if (p_req && !p_ack) begin
          chk("req_held", 32'(imem_req), 32'd1);
          chk("addr_stable", imem_addr, p_addr);
        end
        if (p_redirect) begin
          chk("flush_valid", 32'(if_id_valid), 32'd0);
          chk("flush_instr", if_id_instr, NOP);
          have_last = 1'b0;
        end else if (p_stall) begin
          if (have_last) begin
            chk("stall_instr", if_id_instr, last.instr);
            chk("stall_pc4", if_id_pc4, last.pc4);
          end
        end else if (if_id_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty actual=instr %h expected=none at %0t", if_id_instr, $time);
          end else begin
            got = exp_q.pop_front();
            pops++;
            chk("sb_instr", if_id_instr, got.instr);
            chk("sb_pc4", if_id_pc4, got.pc4);
            last = got;
            have_last = 1'b1;
          end
        end
      end
    end
  end

  // stimulus
  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0000_0000;
    model_pc = 32'h0000_0000;
    #1;
    check_reset_values();
    repeat (2) @(negedge clk);
    topup();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("zw_addr", imem_addr, 32'(4 * k));
      chk("zw_req", 32'(imem_req), 32'd1);
      chk("zw_valid", 32'(if_id_valid), (k == 0) ? 32'd0 : 32'd1);
    end
    max_lat = 2;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c == 1500) begin
        @(posedge clk); #3;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0;
        #1;
        check_reset_values();
        exp_q.delete();
        model_pc = 32'h0000_0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        topup();
      end else begin
        stall    = ($urandom_range(0, 3) == 0);
        redirect = ($urandom_range(0, 19) == 0);
        case ($urandom_range(0, 3))
          0:       redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'h0000_000F);
          default: redirect_pc = $urandom & 32'h0000_0FFF;
        endcase
        if (redirect) begin
          exp_q.delete();
          model_pc = redirect_pc & 32'hFFFF_FFFC;
        end
        topup();
      end
    end
    @(negedge clk);
    stall = 1'b0; redirect = 1'b0;
    repeat (4) @(negedge clk);
    chk("progress", 32'(pops > 200), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
